// File: rtl/param_shift_reg.sv
// Universal shift register: hold, shift right, shift left and parallel load,
// with a shared shift counter that pulses word_done every WIDTH shifts.
module param_shift_reg #(
    parameter int unsigned       WIDTH     = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0,
    parameter int unsigned       CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic [WIDTH-1:0] pdata,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             word_done
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;

    logic [WIDTH-1:0] w_q_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_done_nxt;
    logic             w_wrap;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_wrap    = (r_cnt == CNT_LAST);
    assign w_cnt_inc = r_cnt + CNT_ONE;

    // Next-state: word_done defaults low so a pulse can never stretch.
    always_comb begin
        w_q_nxt    = r_q;
        w_cnt_nxt  = r_cnt;
        w_done_nxt = 1'b0;
        if (en) begin
            unique case (mode)
                MODE_HOLD: begin
                    w_q_nxt = r_q;
                end
                MODE_RIGHT: begin
                    w_q_nxt    = {sin_l, r_q[WIDTH-1:1]};
                    w_cnt_nxt  = w_wrap ? '0 : w_cnt_inc;
                    w_done_nxt = w_wrap;
                end
                MODE_LEFT: begin
                    w_q_nxt    = {r_q[WIDTH-2:0], sin_r};
                    w_cnt_nxt  = w_wrap ? '0 : w_cnt_inc;
                    w_done_nxt = w_wrap;
                end
                MODE_LOAD: begin
                    w_q_nxt   = pdata;
                    w_cnt_nxt = '0;
                end
                default: begin
                    w_q_nxt = r_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q    <= RESET_VAL;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
            r_cnt  <= w_cnt_nxt;
            r_done <= w_done_nxt;
        end
    end

    assign q         = r_q;
    assign bit_cnt   = r_cnt;
    assign word_done = r_done;
    assign sout_l    = r_q[WIDTH-1];
    assign sout_r    = r_q[0];

endmodule

// File: tb/tb_param_shift_reg.sv
// Directed bench for param_shift_reg: vector table on an 8-bit instance plus
// hand sequences for reset, continuous shifting and the WIDTH=2/32 sweep.
module tb_param_shift_reg;

    localparam logic [1:0] MH  = 2'b00;
    localparam logic [1:0] MR  = 2'b01;
    localparam logic [1:0] ML  = 2'b10;
    localparam logic [1:0] MLD = 2'b11;

    logic clk;
    logic reset;

    logic       en;
    logic [1:0] mode;
    logic       sin_l;
    logic       sin_r;
    logic [7:0] pdata;
    logic [7:0] q;
    logic       sout_l;
    logic       sout_r;
    logic [3:0] bit_cnt;
    logic       word_done;

    logic       en2, sin_l2, sin_r2, sout_l2, sout_r2, done2;
    logic [1:0] mode2, pdata2, q2, cnt2;

    logic        en32, sin_l32, sin_r32, sout_l32, sout_r32, done32;
    logic [1:0]  mode32;
    logic [31:0] pdata32, q32;
    logic [5:0]  cnt32;

    int n_checks;
    int n_errors;

    param_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) u_dut8 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .sin_l(sin_l), .sin_r(sin_r),
        .pdata(pdata), .q(q), .sout_l(sout_l), .sout_r(sout_r),
        .bit_cnt(bit_cnt), .word_done(word_done)
    );

    param_shift_reg #(.WIDTH(2)) u_dut2 (
        .clk(clk), .reset(reset), .en(en2), .mode(mode2), .sin_l(sin_l2), .sin_r(sin_r2),
        .pdata(pdata2), .q(q2), .sout_l(sout_l2), .sout_r(sout_r2),
        .bit_cnt(cnt2), .word_done(done2)
    );

    param_shift_reg #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset(reset), .en(en32), .mode(mode32), .sin_l(sin_l32), .sin_r(sin_r32),
        .pdata(pdata32), .q(q32), .sout_l(sout_l32), .sout_r(sout_r32),
        .bit_cnt(cnt32), .word_done(done32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic       sl;
        logic       sr;
        logic [7:0] pd;
        logic [7:0] q;
        logic [3:0] cnt;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic e, input logic [1:0] m, input logic sl,
                                input logic sr, input logic [7:0] pd, input logic [7:0] eq,
                                input logic [3:0] ec, input logic ed);
        vec_t v;
        v.en = e; v.mode = m; v.sl = sl; v.sr = sr; v.pd = pd;
        v.q = eq; v.cnt = ec; v.done = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive the 8-bit instance for one edge; return #1 after that edge.
    task automatic step8(input logic e, input logic [1:0] m, input logic sl,
                         input logic sr, input logic [7:0] pd);
        en = e; mode = m; sin_l = sl; sin_r = sr; pdata = pd;
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] eq, input logic [3:0] ec,
                        input logic ed);
        chk({tag, " q"}, 64'(q), 64'(eq));
        chk({tag, " bit_cnt"}, 64'(bit_cnt), 64'(ec));
        chk({tag, " word_done"}, 64'(word_done), 64'(ed));
        chk({tag, " sout_l"}, 64'(sout_l), 64'(eq[7]));
        chk({tag, " sout_r"}, 64'(sout_r), 64'(eq[0]));
    endtask

    initial begin
        logic [7:0]  mq;
        logic [31:0] mq32;
        logic        b;

        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        en = 1'b0; mode = MH; sin_l = 1'b0; sin_r = 1'b0; pdata = '0;
        en2 = 1'b0; mode2 = MH; sin_l2 = 1'b0; sin_r2 = 1'b0; pdata2 = '0;
        en32 = 1'b0; mode32 = MH; sin_l32 = 1'b0; sin_r32 = 1'b0; pdata32 = '0;

        // Load-and-shift-left 00 with 1,0,1,1,0,0,1,0 -> B2
        vecs.push_back(mk(1, MLD, 0, 0, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(1, ML, 0, 1, 8'h00, 8'h01, 1, 0));
        vecs.push_back(mk(1, ML, 0, 0, 8'h00, 8'h02, 2, 0));
        vecs.push_back(mk(1, ML, 0, 1, 8'h00, 8'h05, 3, 0));
        vecs.push_back(mk(1, ML, 0, 1, 8'h00, 8'h0B, 4, 0));
        vecs.push_back(mk(1, ML, 0, 0, 8'h00, 8'h16, 5, 0));
        vecs.push_back(mk(1, ML, 0, 0, 8'h00, 8'h2C, 6, 0));
        vecs.push_back(mk(1, ML, 0, 1, 8'h00, 8'h59, 7, 0));
        vecs.push_back(mk(1, ML, 0, 0, 8'h00, 8'hB2, 0, 1));
        vecs.push_back(mk(1, MH, 0, 0, 8'h00, 8'hB2, 0, 0));
        // Load 81, shift right with sin_l=0
        vecs.push_back(mk(1, MLD, 0, 0, 8'h81, 8'h81, 0, 0));
        vecs.push_back(mk(1, MR, 0, 0, 8'h00, 8'h40, 1, 0));
        vecs.push_back(mk(1, MR, 0, 0, 8'h00, 8'h20, 2, 0));
        vecs.push_back(mk(1, MR, 0, 0, 8'h00, 8'h10, 3, 0));
        vecs.push_back(mk(1, MR, 0, 0, 8'h00, 8'h08, 4, 0));
        vecs.push_back(mk(1, MR, 0, 0, 8'h00, 8'h04, 5, 0));
        vecs.push_back(mk(1, MR, 0, 0, 8'h00, 8'h02, 6, 0));
        vecs.push_back(mk(1, MR, 0, 0, 8'h00, 8'h01, 7, 0));
        vecs.push_back(mk(1, MR, 0, 0, 8'h00, 8'h00, 0, 1));
        vecs.push_back(mk(1, MH, 0, 0, 8'h00, 8'h00, 0, 0));
        // Enable and hold gaps do not count
        vecs.push_back(mk(1, MLD, 0, 0, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(1, ML, 0, 1, 8'h00, 8'h01, 1, 0));
        vecs.push_back(mk(1, ML, 0, 1, 8'h00, 8'h03, 2, 0));
        vecs.push_back(mk(1, ML, 0, 1, 8'h00, 8'h07, 3, 0));
        vecs.push_back(mk(1, ML, 0, 1, 8'h00, 8'h0F, 4, 0));
        vecs.push_back(mk(0, ML, 0, 1, 8'h00, 8'h0F, 4, 0));
        vecs.push_back(mk(0, MLD, 0, 1, 8'hFF, 8'h0F, 4, 0));
        vecs.push_back(mk(0, MR, 1, 1, 8'h00, 8'h0F, 4, 0));
        vecs.push_back(mk(1, MH, 1, 1, 8'hFF, 8'h0F, 4, 0));
        vecs.push_back(mk(1, MH, 1, 1, 8'hFF, 8'h0F, 4, 0));
        vecs.push_back(mk(1, ML, 0, 0, 8'h00, 8'h1E, 5, 0));
        vecs.push_back(mk(1, ML, 0, 0, 8'h00, 8'h3C, 6, 0));
        vecs.push_back(mk(1, ML, 0, 0, 8'h00, 8'h78, 7, 0));
        vecs.push_back(mk(1, ML, 0, 0, 8'h00, 8'hF0, 0, 1));
        vecs.push_back(mk(1, MH, 0, 0, 8'h00, 8'hF0, 0, 0));
        // Direction change mid-word shares the counter
        vecs.push_back(mk(1, MLD, 0, 0, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(1, ML, 0, 1, 8'h00, 8'h01, 1, 0));
        vecs.push_back(mk(1, ML, 0, 1, 8'h00, 8'h03, 2, 0));
        vecs.push_back(mk(1, ML, 0, 1, 8'h00, 8'h07, 3, 0));
        vecs.push_back(mk(1, ML, 0, 1, 8'h00, 8'h0F, 4, 0));
        vecs.push_back(mk(1, MR, 1, 0, 8'h00, 8'h87, 5, 0));
        vecs.push_back(mk(1, MR, 1, 0, 8'h00, 8'hC3, 6, 0));
        vecs.push_back(mk(1, MR, 1, 0, 8'h00, 8'hE1, 7, 0));
        vecs.push_back(mk(1, MR, 1, 0, 8'h00, 8'hF0, 0, 1));
        vecs.push_back(mk(0, MR, 1, 0, 8'h00, 8'hF0, 0, 0));
        // Load on the would-be 8th shift wins
        vecs.push_back(mk(1, MLD, 0, 0, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(1, ML, 0, 1, 8'h00, 8'h01, 1, 0));
        vecs.push_back(mk(1, ML, 0, 1, 8'h00, 8'h03, 2, 0));
        vecs.push_back(mk(1, ML, 0, 1, 8'h00, 8'h07, 3, 0));
        vecs.push_back(mk(1, ML, 0, 1, 8'h00, 8'h0F, 4, 0));
        vecs.push_back(mk(1, ML, 0, 1, 8'h00, 8'h1F, 5, 0));
        vecs.push_back(mk(1, ML, 0, 1, 8'h00, 8'h3F, 6, 0));
        vecs.push_back(mk(1, ML, 0, 1, 8'h00, 8'h7F, 7, 0));
        vecs.push_back(mk(1, MLD, 0, 1, 8'h5A, 8'h5A, 0, 0));
        vecs.push_back(mk(1, MH, 0, 0, 8'h00, 8'h5A, 0, 0));
        vecs.push_back(mk(1, ML, 0, 1, 8'h00, 8'hB5, 1, 0));

        // Reset value while held in reset
        repeat (2) @(posedge clk);
        #1;
        chk8("in_reset", 8'hA5, 0, 0);
        reset = 1'b1;

        // Asynchronous reset mid-clock with q=3C
        step8(1, MLD, 0, 0, 8'h3C);
        chk8("load_3c", 8'h3C, 0, 0);
        #3;
        reset = 1'b0;
        #1;
        chk8("async_reset", 8'hA5, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset mid-word on the cycle that would complete it leaves nothing pending
        step8(1, MLD, 0, 0, 8'h3C);
        for (int k = 0; k < 7; k++) step8(1, ML, 0, 0, 8'h00);
        chk("pre_reset bit_cnt", 64'(bit_cnt), 64'd7);
        mode = ML;
        #3;
        reset = 1'b0;
        #1;
        chk8("midword_reset", 8'hA5, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step8(1, MH, 0, 0, 8'h00);
        chk8("after_reset_hold", 8'hA5, 0, 0);
        step8(1, ML, 0, 1, 8'h00);
        chk8("after_reset_shift", 8'h4B, 1, 0);

        foreach (vecs[i]) begin
            step8(vecs[i].en, vecs[i].mode, vecs[i].sl, vecs[i].sr, vecs[i].pd);
            chk8($sformatf("vec%0d", i), vecs[i].q, vecs[i].cnt, vecs[i].done);
        end

        // 24 back-to-back shifts: pulses at 8, 16, 24, each one cycle wide
        step8(1, MLD, 0, 0, 8'h00);
        mq = 8'h00;
        for (int k = 1; k <= 24; k++) begin
            b = (k % 3 == 0);
            step8(1, ML, 0, b, 8'h00);
            mq = {mq[6:0], b};
            chk8($sformatf("cont%0d", k), mq, 4'(k % 8), (k % 8 == 0));
        end
        step8(0, ML, 0, 1, 8'h00);
        chk8("cont_after", mq, 0, 0);

        // WIDTH=2 walking one
        en2 = 1'b1; mode2 = MLD; pdata2 = 2'b01; sin_r2 = 1'b0;
        @(posedge clk); #1;
        chk("w2 load", 64'(q2), 64'h1);
        mode2 = ML;
        @(posedge clk); #1;
        chk("w2 shift1 q", 64'(q2), 64'h2);
        chk("w2 shift1 sout_l", 64'(sout_l2), 64'h1);
        chk("w2 shift1 done", 64'(done2), 64'h0);
        chk("w2 shift1 cnt", 64'(cnt2), 64'h1);
        @(posedge clk); #1;
        chk("w2 shift2 q", 64'(q2), 64'h0);
        chk("w2 shift2 done", 64'(done2), 64'h1);
        chk("w2 shift2 cnt", 64'(cnt2), 64'h0);
        en2 = 1'b0;
        @(posedge clk); #1;
        chk("w2 after done", 64'(done2), 64'h0);

        // WIDTH=32 walking one
        en32 = 1'b1; mode32 = MLD; pdata32 = 32'h1; sin_r32 = 1'b0;
        @(posedge clk); #1;
        mq32 = 32'h1;
        chk("w32 load", 64'(q32), 64'(mq32));
        mode32 = ML;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk); #1;
            mq32 = {mq32[30:0], 1'b0};
            chk($sformatf("w32 s%0d q", k), 64'(q32), 64'(mq32));
            chk($sformatf("w32 s%0d cnt", k), 64'(cnt32), 64'(k % 32));
            chk($sformatf("w32 s%0d done", k), 64'(done32), 64'(k == 32));
        end
        chk("w32 sout_l reached", 64'(q32), 64'h0);
        mode32 = MH;
        @(posedge clk); #1;
        chk("w32 after done", 64'(done32), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/param_shift_reg.md
Name: param_shift_reg

Overview:
- Parametrised universal shift register; next generation of the fixed 8-bit serial-in/serial-out chain.
- Adds the following over that chain:
  - configurable width
  - bidirectional shift
  - parallel load and hold modes
  - clock enable
  - shift counter that flags when a full word has been shifted through
- Used as a serializer/deserializer stage between serial links and word-wide datapaths.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.
- RESET_VAL, 0, value loaded into q on reset; WIDTH bits wide.
- CNT_W, $clog2(WIDTH+1), width of bit_cnt; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- en  input  1  clock enable; 0 freezes all state.
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- sin_l  input  1  serial input entering q[WIDTH-1] on shift right.
- sin_r  input  1  serial input entering q[0] on shift left.
- pdata  input  WIDTH  parallel load data.
- q  output  WIDTH  register contents.
- sout_l  output  1  q[WIDTH-1]; combinational from q.
- sout_r  output  1  q[0]; combinational from q.
- bit_cnt  output  CNT_W  shifts performed since last load/wrap.
- word_done  output  1  one-cycle pulse: WIDTH shifts completed.

Behaviour:
- Reset (reset=0, asynchronous, independent of clk and en):
  - q = RESET_VAL, bit_cnt = 0, word_done = 0.
  - Release is sampled synchronously; the first active edge after reset=1 performs the normal operation.
- All state updates occur on the rising edge of clk only when reset=1 and en=1.
- en=0: q and bit_cnt hold; word_done = 0 on the next edge. A pulse never stretches.
- mode 00 (hold): q holds; bit_cnt holds; word_done = 0.
- mode 01 (shift right): q <= {sin_l, q[WIDTH-1:1]}; sout_r presents the outgoing LSB before the edge.
- mode 10 (shift left): q <= {q[WIDTH-2:0], sin_r}. Same data direction as the legacy chain: data enters bit 0 and moves toward the MSB.
- mode 11 (load): q <= pdata; bit_cnt <= 0; word_done = 0.
- Shift counter (modes 01/10 with en=1):
  - If bit_cnt == WIDTH-1: bit_cnt <= 0 and word_done <= 1 in the same edge.
  - Otherwise bit_cnt <= bit_cnt+1 and word_done <= 0.
  - Left and right shifts share one counter. Changing direction mid-word does not clear it.
- Latency: q, bit_cnt and word_done are all registered and update on the same edge. word_done is high during the cycle after the WIDTH-th shift edge, aligned with the q value containing the complete shifted-in word.
- Wrap-around: continuous shifting produces word_done every WIDTH enabled shift cycles with no gap cycle. Disabled or hold cycles interleaved between shifts do not count.
- Simultaneous events:
  - Load during the cycle that would have completed a word: the load wins, bit_cnt=0, no word_done.
  - Reset asserted mid-word: clears immediately, with no pending word_done afterward.
- Combinational outputs: sout_l and sout_r have no other logic between q and the port.
- Unknown or X mode is not a legal input; no behaviour is defined for it.

Test Plan:
- Reset check: WIDTH=8, RESET_VAL=8'hA5, assert reset=0 mid-clock with q=8'h3C -> q=8'hA5, bit_cnt=0, word_done=0 immediately, without waiting for a clk edge.
- Load and shift left: load pdata=8'h00, then 8 left shifts with sin_r pattern 1,0,1,1,0,0,1,0 -> q=8'hB2 and word_done=1 exactly in the cycle after the 8th shift; bit_cnt sequence 1..7,0.
- Load and shift right: load 8'h81, then shift right 8 times with sin_l=0 -> sout_r sequence 1,0,0,0,0,0,0,1; final q=8'h00; one word_done pulse.
- Enable and hold gaps: shift left 4 times, then 3 cycles en=0, then 2 cycles mode=00, then 4 more shifts -> bit_cnt holds at 4 during the gaps; word_done fires only after the 8th actual shift.
- Continuous shifting and load conflict:
  - 24 back-to-back shifts -> word_done pulses at shifts 8, 16 and 24, each exactly one cycle wide.
  - Separate run: load asserted on what would be the 8th shift -> no pulse, bit_cnt=0, q=pdata.
- Parameter sweep: WIDTH=2 and WIDTH=32, each with a walking-one shift-left test -> bit reaches q[WIDTH-1] after WIDTH-1 shifts; word_done after WIDTH shifts.
